// File: rtl/string_streamer.sv
// -----------------------------------------------------------------------------
// string_streamer
//
// Purpose:
//   Locates string N in a NUL-separated string ROM by counting terminators from
//   address 0, then streams that string's characters (with 0-based column
//   index) over a valid/ready handshake. A string that cannot be located before
//   the last valid ROM address is reported with err, raised together with done.
//
// Optional feature (macro STRSTREAM_PAD_EN):
//   When defined, a string that ends on its NUL before MAX_LEN characters is
//   padded with spaces (8'h20) up to MAX_LEN columns. Truncated strings, strings
//   that run into the end of the ROM and not-found strings are never padded.
//   When undefined, streaming simply stops at the NUL.
//
// Ports:
//   clk        in   system clock, all state on rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   request pulse, sampled only in IDLE
//   str_id     in   [ID_W]   string index, captured with start
//   rom_addr   out  [ADDR_W] registered address to the external ROM
//   rom_value  in   [DATA_W] ROM data for rom_addr, same cycle
//   char_valid out  char_data/char_col valid
//   char_ready in   renderer accepts character
//   char_data  out  [DATA_W] character (0 when not valid)
//   char_col   out  [LEN_W]  column of char_data (0 when not valid)
//   busy       out  high in any state other than IDLE
//   done       out  one-cycle pulse at end of request
//   err        out  registered; set with done when string not found,
//                   cleared on the next accepted start
// -----------------------------------------------------------------------------
module string_streamer #(
   parameter int ADDR_W    = 11,
   parameter int DATA_W    = 8,
   parameter int ROM_DEPTH = 2048,
   parameter int ID_W      = 4,
   parameter int LEN_W     = 5,
   parameter int MAX_LEN   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ID_W-1:0]   str_id,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_value,
   output logic              char_valid,
   input  logic              char_ready,
   output logic [DATA_W-1:0] char_data,
   output logic [LEN_W-1:0]  char_col,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEEK = 2'd1,
      EMIT = 2'd2,
      FIN  = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROM_DEPTH - 1);
   localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(MAX_LEN);
   localparam logic [ID_W-1:0]   ONE_ID    = ID_W'(1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q,  addr_d;
   logic [LEN_W-1:0]    len_q,   len_d;
   logic [ID_W-1:0]     skip_q,  skip_d;
   logic                err_q,   err_d;
   // Set when the address has stepped past the last valid ROM location. The
   // address itself may wrap (ROM_DEPTH == 2**ADDR_W), so it cannot be
   // compared against ROM_DEPTH-1 after the increment.
   logic                past_q,  past_d;

   logic                rom_nul;
   assign rom_nul = (rom_value == '0);

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         len_q   <= '0;
         skip_q  <= '0;
         err_q   <= 1'b0;
         past_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         skip_q  <= skip_d;
         err_q   <= err_d;
         past_q  <= past_d;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state and output logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      len_d      = len_q;
      skip_d     = skip_q;
      err_d      = err_q;
      past_d     = past_q;
      char_valid = 1'b0;
      char_data  = '0;
      char_col   = '0;

      case (state_q)
         IDLE: begin
            if (start) begin
               addr_d  = '0;
               len_d   = '0;
               err_d   = 1'b0;
               past_d  = 1'b0;
               skip_d  = str_id;
               state_d = (str_id == '0) ? EMIT : SEEK;
            end
         end

         SEEK: begin
            // skip counts the terminators still to pass; the one that brings
            // it to zero is the NUL just before the wanted string.
            addr_d = addr_q + ADDR_W'(1);
            past_d = (addr_q == LAST_ADDR);
            if (rom_nul && skip_q == ONE_ID) begin
               state_d = EMIT;
            end else begin
               if (rom_nul) begin
                  skip_d = skip_q - ONE_ID;
               end
               if (addr_q == LAST_ADDR) begin
                  err_d   = 1'b1;
                  state_d = FIN;
               end
            end
         end

         EMIT: begin
            if (past_q || len_q == LEN_MAX) begin
               state_d = FIN;
            end else if (rom_nul) begin
`ifdef STRSTREAM_PAD_EN
               // Pad sub-mode: the address stays parked on the NUL, so
               // rom_value keeps reading 0 until the field is full.
               char_valid = 1'b1;
               char_data  = DATA_W'(8'h20);
               char_col   = len_q;
               if (char_ready) begin
                  len_d = len_q + LEN_W'(1);
               end
`else
               state_d = FIN;
`endif
            end else begin
               char_valid = 1'b1;
               char_data  = rom_value;
               char_col   = len_q;
               if (char_ready) begin
                  addr_d = addr_q + ADDR_W'(1);
                  len_d  = len_q + LEN_W'(1);
                  past_d = (addr_q == LAST_ADDR);
               end
            end
         end

         FIN: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign rom_addr = addr_q;
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == FIN);
   assign err      = err_q;

endmodule

// File: tb/tb_string_streamer.sv
// -----------------------------------------------------------------------------
// tb_string_streamer
//
// Three instances share start/str_id/char_ready:
//   u0: MAX_LEN=16, ROM_DEPTH=2048   u1: MAX_LEN=4, ROM_DEPTH=2048
//   u2: MAX_LEN=12, ROM_DEPTH=45
// Expected characters and per-request outcomes come from a string-level model
// of the ROM contents and are queued when a request is issued; one monitor
// process pops and compares on every accepted character and done pulse.
// -----------------------------------------------------------------------------
module tb_string_streamer;

   localparam int N = 3;

   typedef struct {
      logic [7:0] d;
      logic [4:0] c;
   } ch_t;

   typedef struct {
      bit err;
      int lat;
      int n;
   } rq_t;

   logic clk = 1'b0;
   logic rst_n, start, ready;
   logic [3:0] str_id;

   logic [7:0] rom_mem [0:2047];

   logic [N-1:0][10:0] addr_a;
   logic [N-1:0][7:0]  val_a, dat_a;
   logic [N-1:0][4:0]  col_a;
   logic [N-1:0]       vld_a, busy_a, done_a, err_a;

   int cyc = 0;
   int mode;
   int req_cnt, to_cnt;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar gi = 0; gi < N; gi++) begin : g
      localparam int DP = (gi == 2) ? 45 : 2048;
      localparam int ML = (gi == 0) ? 16 : (gi == 1) ? 4 : 12;
      assign val_a[gi] = rom_mem[addr_a[gi]];
      string_streamer #(
         .ADDR_W(11), .DATA_W(8), .ROM_DEPTH(DP), .ID_W(4), .LEN_W(5), .MAX_LEN(ML)
      ) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .start      (start),
         .str_id     (str_id),
         .rom_addr   (addr_a[gi]),
         .rom_value  (val_a[gi]),
         .char_valid (vld_a[gi]),
         .char_ready (ready),
         .char_data  (dat_a[gi]),
         .char_col   (col_a[gi]),
         .busy       (busy_a[gi]),
         .done       (done_a[gi]),
         .err        (err_a[gi])
      );
   end

   function automatic int depth(input logic [1:0] i);
      return (i == 2'd2) ? 45 : 2048;
   endfunction

   function automatic int maxl(input logic [1:0] i);
      return (i == 2'd0) ? 16 : (i == 2'd1) ? 4 : 12;
   endfunction

   // ---------------------------------------------------------------- model
   ch_t chq [N][$];
   rq_t rqq [N][$];
   int  ndone [N];

   // String id 0 starts at address 0; string k starts right after the k-th
   // NUL found inside the ROM. Characters run until NUL, field full or ROM end.
   function automatic void push_model(input logic [1:0] i, input int id);
      int  a = 0;
      int  nul = 0;
      int  n = 0;
      bit  found = (id == 0);
      rq_t r;
      ch_t c;
      while (!found && a < depth(i)) begin
         if (rom_mem[11'(a)] == 8'h00) begin
            nul++;
            found = (nul == id);
         end
         a++;
      end
      r.err = !found;
      r.lat = found ? ((id == 0) ? 1 : 1 + a) : depth(i);
      if (found) begin
         while (n < maxl(i) && a + n < depth(i) && rom_mem[11'(a + n)] != 8'h00) begin
            c.d = rom_mem[11'(a + n)];
            c.c = 5'(n);
            chq[i].push_back(c);
            n++;
         end
`ifdef STRSTREAM_PAD_EN
         if (n < maxl(i) && a + n < depth(i)) begin
            while (n < maxl(i)) begin
               c.d = 8'h20;
               c.c = 5'(n);
               chq[i].push_back(c);
               n++;
            end
         end
`endif
      end
      r.n = n;
      rqq[i].push_back(r);
   endfunction

   // -------------------------------------------------------------- monitor
   int         seen_req = 0;
   int         to_seen = 0;
   int         req_cyc = 0;
   int         exp_cyc;
   int         last_acc [N];
   bit         got_first [N];
   bit         stall [N];
   logic [7:0] sd [N];
   logic [4:0] sc [N];
   logic [1:0] k;
   ch_t        mc;
   rq_t        mr;

   always @(negedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            k = 2'(i);
            checks++;
            if (busy_a[k] || vld_a[k] || done_a[k] || err_a[k] || addr_a[k] != 11'd0) begin
               errors++;
               $display("FAIL reset_state u%0d: busy=%b valid=%b done=%b err=%b addr=%0d, want all 0",
                        i, busy_a[k], vld_a[k], done_a[k], err_a[k], addr_a[k]);
            end
            chq[k].delete();
            rqq[k].delete();
            stall[k] = 1'b0;
            got_first[k] = 1'b0;
         end
         seen_req = req_cnt;
      end else begin
         if (to_cnt != to_seen) begin
            to_seen = to_cnt;
            checks++;
            errors++;
            $display("FAIL timeout: request %0d got no done on every instance within budget", req_cnt);
         end
         if (req_cnt != seen_req) begin
            seen_req = req_cnt;
            req_cyc  = cyc;
            for (int i = 0; i < N; i++) begin
               k = 2'(i);
               push_model(k, int'(str_id));
               got_first[k] = 1'b0;
            end
         end
         for (int i = 0; i < N; i++) begin
            k = 2'(i);
            checks++;
            if (busy_a[k] && rqq[k].size() == 0) begin
               errors++;
               $display("FAIL spurious_busy u%0d: busy=1 with no request outstanding", i);
            end
            if (stall[k]) begin
               checks++;
               if (!vld_a[k] || dat_a[k] != sd[k] || col_a[k] != sc[k]) begin
                  errors++;
                  $display("FAIL hold u%0d: valid=%b data=%h col=%0d, want valid=1 data=%h col=%0d",
                           i, vld_a[k], dat_a[k], col_a[k], sd[k], sc[k]);
               end
            end
            if (vld_a[k]) begin
               if (!got_first[k]) begin
                  got_first[k] = 1'b1;
                  checks++;
                  if (rqq[k].size() == 0) begin
                     errors++;
                     $display("FAIL unexpected_valid u%0d: data=%h", i, dat_a[k]);
                  end else if (cyc - req_cyc != rqq[k][0].lat) begin
                     errors++;
                     $display("FAIL first_latency u%0d: got %0d cycles, want %0d",
                              i, cyc - req_cyc, rqq[k][0].lat);
                  end
               end
               if (ready) begin
                  checks++;
                  if (chq[k].size() == 0) begin
                     errors++;
                     $display("FAIL extra_char u%0d: data=%h col=%0d, none expected", i, dat_a[k], col_a[k]);
                  end else begin
                     mc = chq[k].pop_front();
                     if (dat_a[k] != mc.d || col_a[k] != mc.c) begin
                        errors++;
                        $display("FAIL char u%0d: data=%h col=%0d, want data=%h col=%0d",
                                 i, dat_a[k], col_a[k], mc.d, mc.c);
                     end
                  end
                  last_acc[k] = cyc;
               end
               stall[k] = !ready;
               sd[k] = dat_a[k];
               sc[k] = col_a[k];
            end else begin
               stall[k] = 1'b0;
               checks++;
               if (dat_a[k] != 8'h00 || col_a[k] != 5'd0) begin
                  errors++;
                  $display("FAIL idle_zero u%0d: data=%h col=%0d while not valid, want 0/0",
                           i, dat_a[k], col_a[k]);
               end
            end
            if (done_a[k]) begin
               ndone[k]++;
               checks++;
               if (rqq[k].size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_done u%0d: done with no request outstanding", i);
               end else begin
                  mr = rqq[k].pop_front();
                  if (err_a[k] != mr.err) begin
                     errors++;
                     $display("FAIL err u%0d: err=%b, want %b", i, err_a[k], mr.err);
                  end
                  checks++;
                  if (chq[k].size() != 0) begin
                     errors++;
                     $display("FAIL missing_chars u%0d: %0d chars not delivered, next want col %0d",
                              i, chq[k].size(), chq[k][0].c);
                     chq[k].delete();
                  end
                  checks++;
                  exp_cyc = (mr.n == 0) ? req_cyc + mr.lat + 1 : last_acc[k] + 2;
                  if (cyc != exp_cyc) begin
                     errors++;
                     $display("FAIL done_time u%0d: done at cycle %0d, want %0d", i, cyc, exp_cyc);
                  end
               end
               got_first[k] = 1'b0;
            end
         end
      end
   end

   // ------------------------------------------------------------- stimulus
   initial begin
      ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (mode)
            0:       ready = 1'b1;
            1:       ready = ~ready;
            default: ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic put_str(input int base, input string s);
      for (int j = 0; j < s.len(); j++) rom_mem[11'(base + j)] = s[j];
   endtask

   function automatic bit all_done();
      for (int i = 0; i < N; i++) if (ndone[i] != req_cnt) return 1'b0;
      return 1'b1;
   endfunction

   task automatic do_req(input int id, input int m);
      int w;
      @(posedge clk);
      #1;
      mode   = m;
      str_id = 4'(id);
      start  = 1'b1;
      req_cnt++;
      @(posedge clk);
      #1;
      start = 1'b0;
      w = 0;
      while (!all_done() && w < 4000) begin
         @(posedge clk);
         w++;
      end
      if (!all_done()) begin
         to_cnt++;
         @(negedge clk);
      end
   endtask

   initial begin
      rst_n   = 1'b1;
      start   = 1'b0;
      str_id  = 4'd0;
      mode    = 0;
      req_cnt = 0;
      to_cnt  = 0;
      for (int i = 0; i < N; i++) ndone[i] = 0;
      for (int a = 0; a < 2048; a++) rom_mem[a] = 8'h00;
      put_str(0,  "!MASTER SCOPE!");
      put_str(15, "Ch1 Vdiv:");
      put_str(25, "Ch2 Vdiv:");
      put_str(35, "Time Div:");
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      do_req(0, 0);   // first string, full field / truncated to 4 on u1
      do_req(1, 0);   // one terminator to skip
      do_req(3, 1);   // ready toggling every cycle
      do_req(5, 0);   // not found on the 45-deep instance
      do_req(2, 0);   // err cleared by the next accepted start
      do_req(4, 1);   // empty / ends exactly at ROM end on u2
      do_req(2, 2);
      for (int r = 0; r < 30; r++) do_req(int'($urandom_range(0, 6)), int'($urandom_range(0, 2)));

      // Reset in the middle of streaming string 0: outputs drop at once and
      // no done may follow.
      @(posedge clk);
      #1;
      mode   = 0;
      str_id = 4'd0;
      start  = 1'b1;
      req_cnt++;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
